// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter: strobes in, registered count and flag out.
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    // No handshake: en/up_dn/load/load_val are level strobes sampled at every
    // rising clk edge; bin_out/gray_out/tc are registered and valid every cycle.
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             tc;

    modport master (
        output en, up_dn, load, load_val,
        input  bin_out, gray_out, tc
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output bin_out, gray_out, tc
    );
endinterface

// File: rtl/gray_counter.sv
// Registered up/down binary counter with aligned Gray output, parallel load,
// wrap or saturate at the limits, and a one-cycle terminal-count flag.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    gray_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] MIN_VAL = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;

    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (bin_q == MAX_VAL) begin
                    tc_d  = 1'b1;
                    bin_d = WRAP ? MIN_VAL : bin_q;
                end else begin
                    bin_d = bin_q + ONE;
                end
            end else begin
                if (bin_q == MIN_VAL) begin
                    tc_d  = 1'b1;
                    bin_d = WRAP ? MAX_VAL : bin_q;
                end else begin
                    bin_d = bin_q - ONE;
                end
            end
        end
        // Gray is derived from the next binary value so both outputs land on the same edge.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.tc       = tc_q;
endmodule
